// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle controller and the CPU datapath/memory.
// Debug state and the sticky fault flag travel with the control strobes.
interface mc_control_fsm_if;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       inc_PC;
  logic       pc_src;
  logic       halt;
  logic       ir_load;
  logic       mem_read;
  logic       mem_write;
  logic       addr_sel;
  logic       alu_src_imm;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       wb_sel;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output inc_PC, pc_src, halt, ir_load, mem_read, mem_write, addr_sel,
           alu_src_imm, alu_op, reg_write, wb_sel, fault, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  inc_PC, pc_src, halt, ir_load, mem_read, mem_write, addr_sel,
           alu_src_imm, alu_op, reg_write, wb_sel, fault, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the 16-bit CPU,
// with a memory-wait watchdog that parks the core in HALTED with fault set.
module mc_control_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic             clk,
  input logic             reset_n,
  mc_control_fsm_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [7:0] WAIT_LIM = 8'(MEM_WAIT_MAX);

  logic [2:0] st, st_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       flt, flt_nxt;

  logic       inc_pc_c, pc_src_c, halt_c, ir_load_c, mem_read_c, mem_write_c;
  logic       addr_sel_c, alu_src_imm_c, reg_write_c, wb_sel_c;
  logic [1:0] alu_op_c;
  logic       is_ld;

  assign is_ld = (bus.opcode == OP_LD);

  always_comb begin
    st_nxt        = st;
    wcnt_nxt      = '0;
    flt_nxt       = flt;
    inc_pc_c      = 1'b0;
    pc_src_c      = 1'b0;
    halt_c        = 1'b0;
    ir_load_c     = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    addr_sel_c    = 1'b0;
    alu_src_imm_c = 1'b0;
    alu_op_c      = 2'b00;
    reg_write_c   = 1'b0;
    wb_sel_c      = 1'b0;

    unique case (st)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (bus.mem_ready) begin
          ir_load_c = 1'b1;
          inc_pc_c  = 1'b1;
          st_nxt    = S_DECODE;
        end else if (wcnt >= WAIT_LIM) begin
          st_nxt  = S_HALTED;
          flt_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      S_DECODE: begin
        unique case (bus.opcode)
          OP_NOP:                     st_nxt = S_FETCH;
          OP_HLT:                     st_nxt = S_HALTED;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
          OP_LD, OP_ST, OP_BEQ, OP_BNE, OP_JMP: st_nxt = S_EXEC;
          default: begin
            st_nxt  = S_HALTED;
            flt_nxt = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        st_nxt = S_FETCH;
        unique case (bus.opcode)
          OP_ADD: begin alu_op_c = 2'b00; st_nxt = S_WB; end
          OP_SUB: begin alu_op_c = 2'b01; st_nxt = S_WB; end
          OP_AND: begin alu_op_c = 2'b10; st_nxt = S_WB; end
          OP_OR:  begin alu_op_c = 2'b11; st_nxt = S_WB; end
          OP_ADDI: begin alu_src_imm_c = 1'b1; st_nxt = S_WB; end
          OP_LD, OP_ST: begin alu_src_imm_c = 1'b1; st_nxt = S_MEM; end
          OP_BEQ: begin alu_op_c = 2'b01; pc_src_c = bus.zero; end
          OP_BNE: begin alu_op_c = 2'b01; pc_src_c = ~bus.zero; end
          OP_JMP: pc_src_c = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        addr_sel_c  = 1'b1;
        mem_read_c  = is_ld;
        mem_write_c = ~is_ld;
        if (bus.mem_ready) begin
          st_nxt = is_ld ? S_WB : S_FETCH;
        end else if (wcnt >= WAIT_LIM) begin
          st_nxt  = S_HALTED;
          flt_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        wb_sel_c    = is_ld;
        st_nxt      = S_FETCH;
      end
      S_HALTED: halt_c = 1'b1;
      default:  st_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st   <= S_FETCH;
      wcnt <= '0;
      flt  <= 1'b0;
    end else begin
      st   <= st_nxt;
      wcnt <= wcnt_nxt;
      flt  <= flt_nxt;
    end
  end

  // Everything is silenced while reset is held, including the debug state.
  assign bus.inc_PC      = reset_n & inc_pc_c;
  assign bus.pc_src      = reset_n & pc_src_c;
  assign bus.halt        = reset_n & halt_c;
  assign bus.ir_load     = reset_n & ir_load_c;
  assign bus.mem_read    = reset_n & mem_read_c;
  assign bus.mem_write   = reset_n & mem_write_c;
  assign bus.addr_sel    = reset_n & addr_sel_c;
  assign bus.alu_src_imm = reset_n & alu_src_imm_c;
  assign bus.alu_op      = reset_n ? alu_op_c : 2'b00;
  assign bus.reg_write   = reset_n & reg_write_c;
  assign bus.wb_sel      = reset_n & wb_sel_c;
  assign bus.fault       = reset_n & flt;
  assign bus.state       = reset_n ? st : S_FETCH;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench: driver queues the expected per-cycle outputs,
// a negedge monitor pops and compares them against the controller.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic reset_n;

  mc_control_fsm_if bif ();

  mc_control_fsm #(.MEM_WAIT_MAX(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  // ctl = {inc_PC, pc_src, halt, ir_load, mem_read, mem_write,
  //        addr_sel, alu_src_imm, alu_op[1:0], reg_write, wb_sel}
  localparam logic [11:0] C_0    = 12'h000;
  localparam logic [11:0] C_FR   = 12'h980;
  localparam logic [11:0] C_FW   = 12'h080;
  localparam logic [11:0] C_SUB  = 12'h004;
  localparam logic [11:0] C_AND  = 12'h008;
  localparam logic [11:0] C_OR   = 12'h00C;
  localparam logic [11:0] C_IMM  = 12'h010;
  localparam logic [11:0] C_BR1  = 12'h404;
  localparam logic [11:0] C_BR0  = 12'h004;
  localparam logic [11:0] C_JMP  = 12'h400;
  localparam logic [11:0] C_MLD  = 12'h0A0;
  localparam logic [11:0] C_MST  = 12'h060;
  localparam logic [11:0] C_WB   = 12'h002;
  localparam logic [11:0] C_WBLD = 12'h003;
  localparam logic [11:0] C_HLT  = 12'h200;

  typedef struct {
    logic [2:0]  st;
    logic        flt;
    logic [11:0] ctl;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic step(input logic rn, input logic [3:0] op, input logic z,
                      input logic rdy, input logic [2:0] es, input logic ef,
                      input logic [11:0] ec, input string nm);
    @(posedge clk);
    #1;
    reset_n       = rn;
    bif.opcode    = op;
    bif.zero      = z;
    bif.mem_ready = rdy;
    sb.push_back('{st: es, flt: ef, ctl: ec, nm: nm});
  endtask

  task automatic fetch_dec(input logic [3:0] op);
    step(1'b1, op, 1'b0, 1'b1, 3'd0, 1'b0, C_FR, "fetch");
    step(1'b1, op, 1'b0, 1'b1, 3'd1, 1'b0, C_0,  "decode");
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_t e;
        logic [15:0] act, req;
        e   = sb.pop_front();
        act = {bif.state, bif.fault, bif.inc_PC, bif.pc_src, bif.halt,
               bif.ir_load, bif.mem_read, bif.mem_write, bif.addr_sel,
               bif.alu_src_imm, bif.alu_op, bif.reg_write, bif.wb_sel};
        req = {e.st, e.flt, e.ctl};
        checks++;
        if (act !== req) begin
          fails++;
          $display("FAIL %s: got %h expected %h (t=%0t)", e.nm, act, req, $time);
        end
        checks++;
        if ((bif.inc_PC && bif.pc_src) || (bif.mem_read && bif.mem_write) ||
            (bif.halt && (bif.inc_PC || bif.pc_src || bif.mem_read || bif.mem_write))) begin
          fails++;
          $display("FAIL exclusive_%s: got %h expected no overlap", e.nm, act);
        end
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    bif.opcode    = 4'h0;
    bif.zero      = 1'b0;
    bif.mem_ready = 1'b0;

    step(1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, C_0, "reset0");
    step(1'b0, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0, C_0, "reset1");

    // ALU group
    fetch_dec(4'h1);
    step(1'b1, 4'h1, 1'b0, 1'b1, 3'd2, 1'b0, C_0,   "exec_add");
    step(1'b1, 4'h1, 1'b0, 1'b1, 3'd4, 1'b0, C_WB,  "wb_add");
    fetch_dec(4'h2);
    step(1'b1, 4'h2, 1'b0, 1'b1, 3'd2, 1'b0, C_SUB, "exec_sub");
    step(1'b1, 4'h2, 1'b0, 1'b1, 3'd4, 1'b0, C_WB,  "wb_sub");
    fetch_dec(4'h3);
    step(1'b1, 4'h3, 1'b0, 1'b1, 3'd2, 1'b0, C_AND, "exec_and");
    step(1'b1, 4'h3, 1'b0, 1'b1, 3'd4, 1'b0, C_WB,  "wb_and");
    fetch_dec(4'h4);
    step(1'b1, 4'h4, 1'b0, 1'b1, 3'd2, 1'b0, C_OR,  "exec_or");
    step(1'b1, 4'h4, 1'b0, 1'b1, 3'd4, 1'b0, C_WB,  "wb_or");
    fetch_dec(4'h5);
    step(1'b1, 4'h5, 1'b0, 1'b1, 3'd2, 1'b0, C_IMM, "exec_addi");
    step(1'b1, 4'h5, 1'b0, 1'b1, 3'd4, 1'b0, C_WB,  "wb_addi");

    // LD with three memory wait cycles
    fetch_dec(4'h6);
    step(1'b1, 4'h6, 1'b0, 1'b1, 3'd2, 1'b0, C_IMM, "exec_ld");
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'h6, 1'b0, 1'b0, 3'd3, 1'b0, C_MLD, "mem_ld_wait");
    step(1'b1, 4'h6, 1'b0, 1'b1, 3'd3, 1'b0, C_MLD,  "mem_ld_rdy");
    step(1'b1, 4'h6, 1'b0, 1'b1, 3'd4, 1'b0, C_WBLD, "wb_ld");

    // ST, zero wait
    fetch_dec(4'h7);
    step(1'b1, 4'h7, 1'b0, 1'b1, 3'd2, 1'b0, C_IMM, "exec_st");
    step(1'b1, 4'h7, 1'b0, 1'b1, 3'd3, 1'b0, C_MST, "mem_st");

    // Branches and jump
    fetch_dec(4'h8);
    step(1'b1, 4'h8, 1'b1, 1'b1, 3'd2, 1'b0, C_BR1, "beq_z1");
    fetch_dec(4'h8);
    step(1'b1, 4'h8, 1'b0, 1'b1, 3'd2, 1'b0, C_BR0, "beq_z0");
    fetch_dec(4'h9);
    step(1'b1, 4'h9, 1'b0, 1'b1, 3'd2, 1'b0, C_BR1, "bne_z0");
    fetch_dec(4'h9);
    step(1'b1, 4'h9, 1'b1, 1'b1, 3'd2, 1'b0, C_BR0, "bne_z1");
    fetch_dec(4'hA);
    step(1'b1, 4'hA, 1'b0, 1'b1, 3'd2, 1'b0, C_JMP, "exec_jmp");
    fetch_dec(4'h0);

    // Watchdog in FETCH: 16 wait cycles, then HALTED with fault
    for (int i = 0; i < 16; i++)
      step(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, C_FW, "fetch_wait");
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'h0, 1'b0, 1'b1, 3'd5, 1'b1, C_HLT, "wdog_halted");
    step(1'b0, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0, C_0, "wdog_reset");
    fetch_dec(4'h0);

    // HLT: fault stays clear
    fetch_dec(4'hF);
    step(1'b1, 4'hF, 1'b0, 1'b1, 3'd5, 1'b0, C_HLT, "hlt_halted");
    step(1'b1, 4'hF, 1'b0, 1'b1, 3'd5, 1'b0, C_HLT, "hlt_stay");
    step(1'b0, 4'hF, 1'b0, 1'b1, 3'd0, 1'b0, C_0,   "hlt_reset");

    // Illegal opcode C
    fetch_dec(4'hC);
    step(1'b1, 4'hC, 1'b0, 1'b1, 3'd5, 1'b1, C_HLT, "illegal_halted");
    step(1'b1, 4'hC, 1'b0, 1'b1, 3'd5, 1'b1, C_HLT, "illegal_stay");
    step(1'b0, 4'hC, 1'b0, 1'b1, 3'd0, 1'b0, C_0,   "illegal_reset");

    // Reset during MEM of ST
    fetch_dec(4'h7);
    step(1'b1, 4'h7, 1'b0, 1'b1, 3'd2, 1'b0, C_IMM, "exec_st2");
    step(1'b1, 4'h7, 1'b0, 1'b0, 3'd3, 1'b0, C_MST, "mem_st_wait");
    step(1'b0, 4'h7, 1'b0, 1'b0, 3'd0, 1'b0, C_0,   "rst_mid_mem");
    step(1'b1, 4'h7, 1'b0, 1'b0, 3'd0, 1'b0, C_FW,  "fetch_after_rst");
    fetch_dec(4'h0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the 16-bit CPU; sits directly upstream of the program counter and drives its `inc_PC`, `pc_src` and `halt` inputs.
- Sequences FETCH/DECODE/EXEC/MEM/WB for each instruction and handshakes with memory via `mem_ready`.
- Drives the IR load, datapath selects and register-file write enables.
- Contains a memory-wait watchdog that halts the CPU with `fault` set.

Parameters:
- MEM_WAIT_MAX, 15: max consecutive cycles waiting for `mem_ready` (FETCH or MEM) before fault; legal range 1..255.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  synchronous reset, active-low.
- opcode  input  4  IR[15:12]; valid from DECODE onward.
- zero  input  1  ALU zero flag; valid in EXEC.
- mem_ready  input  1  memory completes the current read/write this cycle.
- inc_PC  output  1  PC increment pulse.
- pc_src  output  1  PC loads branch/jump target.
- halt  output  1  PC freeze.
- ir_load  output  1  IR captures memory read data.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- addr_sel  output  1  memory address: 0 = PC, 1 = ALU result.
- alu_src_imm  output  1  ALU B operand: 0 = register, 1 = immediate.
- alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- reg_write  output  1  register-file write enable.
- wb_sel  output  1  writeback source: 0 = ALU, 1 = memory data.
- fault  output  1  sticky: watchdog timeout or illegal opcode.
- state  output  3  debug encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5.

Behaviour:
- State register, wait counter (8 bit) and `fault` update on rising `clk`.
- All other outputs are combinational from state, opcode, zero, mem_ready.
- Reset (`reset_n` = 0 at a rising edge):
  - state becomes FETCH, wait counter 0, `fault` 0.
  - Applies mid-instruction with no completion of the pending access.
  - While `reset_n` is low, all outputs are forced to 0.
- Top level drives the PC's active-high reset from `~reset_n`.
- Opcode map:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 ADDI; 6 LD; 7 ST; 8 BEQ; 9 BNE; A JMP; F HLT.
  - B–E are illegal.
- FETCH:
  - `mem_read`=1, `addr_sel`=0.
  - If `mem_ready`: `ir_load`=1 and `inc_PC`=1 in the same cycle, then go to DECODE, counter cleared.
  - Else counter increments. When the counter reaches MEM_WAIT_MAX with `mem_ready` still 0, the next state is HALTED and `fault` is set. The counter does not wrap.
- DECODE (no outputs asserted):
  - NOP: go to FETCH.
  - HLT: go to HALTED, `fault` unchanged.
  - Illegal opcode: go to HALTED, `fault` set.
  - All other opcodes: go to EXEC.
- EXEC:
  - ADD/SUB/AND/OR: `alu_op` = 00/01/10/11, `alu_src_imm`=0; go to WB.
  - ADDI: `alu_op`=00, `alu_src_imm`=1; go to WB.
  - LD/ST: `alu_op`=00, `alu_src_imm`=1 (address calculation); go to MEM.
  - BEQ: `pc_src` = `zero`; BNE: `pc_src` = !`zero`; `alu_op`=01. Go to FETCH.
  - JMP: `pc_src`=1; go to FETCH.
- MEM:
  - `addr_sel`=1. LD asserts `mem_read`=1; ST asserts `mem_write`=1.
  - On `mem_ready`: LD goes to WB, ST goes to FETCH.
  - Watchdog identical to FETCH.
- WB:
  - `reg_write`=1 for one cycle; `wb_sel`=1 for LD, else 0. Go to FETCH.
- HALTED:
  - `halt`=1; all other pulse outputs 0. Remains in HALTED until reset.
- Cycle counts with zero-wait memory:
  - NOP 2; branch/JMP 3; ALU/ADDI/ST 4; LD 5.
  - Each memory wait cycle adds 1.
- Exclusivity:
  - `inc_PC` and `pc_src` are never asserted together.
  - `mem_read` and `mem_write` are never asserted together.
  - Any of these in the same cycle as `halt` is a design error.

Test Plan:
- Reset, then ADD (opcode 1) with `mem_ready` tied 1 → states 0,1,2,4,0; `inc_PC` only in cycle 0; `reg_write`=1, `wb_sel`=0 in cycle 3.
- LD (6) with `mem_ready` low 3 cycles in MEM → `mem_read` + `addr_sel`=1 held 4 cycles; WB with `wb_sel`=1; total 8 cycles.
- BEQ with `zero`=1, then BEQ with `zero`=0, then BNE with `zero`=0 → `pc_src` = 1, 0, 1 in EXEC; `inc_PC` only in FETCH.
- `mem_ready` held 0 in FETCH, MEM_WAIT_MAX=15 → HALTED at cycle 16, `fault`=1, `halt`=1 stays; `reset_n` low 1 cycle → FETCH, `fault`=0.
- HLT (F) → HALTED with `fault`=0. Opcode C → HALTED with `fault`=1; no `reg_write`/`mem_write` ever asserted.
- `reset_n` dropped during MEM of ST → all outputs 0 that cycle; next cycle FETCH with `mem_write`=0.
